// File: rtl/lfsr4_checker_if.sv
// Sample/status bundle between an LFSR source and lfsr4_checker.
// LFSR4_CHK_PERIOD_EN adds the period/period_vld outputs.
interface lfsr4_checker_if #(
  parameter int ECW = 8
);
  logic           din_vld;
  logic [3:0]     din;
  logic           locked;
  logic           err;
  logic [ECW-1:0] err_cnt;
  logic           zero_det;
`ifdef LFSR4_CHK_PERIOD_EN
  logic [4:0]     period;
  logic           period_vld;

  modport master (
    output din_vld, din,
    input  locked, err, err_cnt, zero_det,
    input  period, period_vld
  );
  modport slave (
    input  din_vld, din,
    output locked, err, err_cnt, zero_det,
    output period, period_vld
  );
`else
  modport master (
    output din_vld, din,
    input  locked, err, err_cnt, zero_det
  );
  modport slave (
    input  din_vld, din,
    output locked, err, err_cnt, zero_det
  );
`endif
endinterface

// File: rtl/lfsr4_checker.sv
// Self-synchronising monitor for the 4-bit LFSR q = {q[2:0], q[3]^q[0]}.
// Define LFSR4_CHK_PERIOD_EN to add the 0001-recurrence period measurement.
module lfsr4_checker #(
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 3,
  parameter int ECW      = 8
) (
  input logic           clk,
  input logic           reset,
  lfsr4_checker_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH,
    SYNC,
    LOCKED
  } state_e;

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] MISS_C = 4'(MISS_MAX);

  function automatic logic [3:0] nxt(
    input logic [3:0] q
  );
    return {q[2:0], q[3] ^ q[0]};
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     pred_q, pred_d;
  logic [3:0]     match_q, match_d;
  logic [3:0]     miss_q, miss_d;
  logic           locked_q, locked_d;
  logic           err_q, err_d;
  logic [ECW-1:0] err_cnt_q, err_cnt_d;
  logic           zero_q, zero_d;
  logic           din_zero;

  assign din_zero = (bus.din == 4'd0);

  always_comb begin
    state_d   = state_q;
    pred_d    = pred_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    zero_d    = 1'b0;
    if (bus.din_vld) begin
      zero_d = din_zero;
      unique case (state_q)
        SEARCH: begin
          if (!din_zero) begin
            pred_d  = nxt(bus.din);
            match_d = 4'd0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (din_zero) begin
            match_d = 4'd0;
            state_d = SEARCH;
          end else if (bus.din == pred_q) begin
            pred_d = nxt(bus.din);
            if (match_q + 4'd1 == LOCK_C) begin
              match_d = 4'd0;
              state_d = LOCKED;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else begin
            pred_d  = nxt(bus.din);
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          // predictor freewheels so one bad sample cannot derail it
          pred_d = nxt(pred_q);
          if (bus.din == pred_q) begin
            miss_d = 4'd0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (miss_q + 4'd1 == MISS_C) begin
              miss_d  = 4'd0;
              state_d = SEARCH;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEARCH;
      pred_q    <= 4'd0;
      match_q   <= 4'd0;
      miss_q    <= 4'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.locked   = locked_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.zero_det = zero_q;

`ifdef LFSR4_CHK_PERIOD_EN
  // per_cnt == 0 means not yet armed by a 0001 since lock
  logic [4:0] per_cnt_q, per_cnt_d;
  logic [4:0] period_q, period_d;
  logic       per_vld_q, per_vld_d;

  always_comb begin
    per_cnt_d = per_cnt_q;
    period_d  = period_q;
    per_vld_d = 1'b0;
    if (state_q != LOCKED) begin
      per_cnt_d = 5'd0;
    end else if (bus.din_vld) begin
      if (bus.din == 4'd1) begin
        if (per_cnt_q != 5'd0) begin
          period_d  = per_cnt_q;
          per_vld_d = 1'b1;
        end
        per_cnt_d = 5'd1;
      end else if (per_cnt_q != 5'd0 && per_cnt_q != 5'd31) begin
        per_cnt_d = per_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt_q <= 5'd0;
      period_q  <= 5'd0;
      per_vld_q <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      per_vld_q <= per_vld_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.period_vld = per_vld_q;
`endif

endmodule

// File: tb/tb_lfsr4_checker.sv
// Randomised bench for lfsr4_checker against a sample-level reference model.
// Define LFSR4_CHK_PERIOD_EN to also exercise the period outputs.
module tb_lfsr4_checker;

  localparam int LOCK_CNT = 4;
  localparam int MISS_MAX = 3;
  localparam int ECW      = 8;
  localparam int ECMAX    = (1 << ECW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lfsr4_checker_if #(.ECW(ECW)) bus();

  lfsr4_checker #(
    .LOCK_CNT(LOCK_CNT),
    .MISS_MAX(MISS_MAX),
    .ECW(ECW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: mode 0 searching, 1 syncing, 2 locked
  int m_mode, m_pred, m_run, m_miss, m_ecnt;
  int m_locked, m_err, m_zd;
  int m_since, m_period, m_pv;
  int g;

  function automatic int nx(int q);
    return ((q << 1) & 14) | (((q >> 3) ^ q) & 1);
  endfunction

  function automatic logic [ECW+2:0] obs();
    return {bus.locked, bus.err, bus.err_cnt, bus.zero_det};
  endfunction

  function automatic logic [ECW+2:0] expv();
    logic [ECW-1:0] c;
    c = m_ecnt[ECW-1:0];
    return {m_locked[0], m_err[0], c, m_zd[0]};
  endfunction

  task automatic model(bit rst, bit vld, int d);
    int old;
    int p;
    old   = m_mode;
    m_err = 0;
    m_zd  = 0;
    m_pv  = 0;
    if (rst) begin
      m_mode = 0; m_pred = 0; m_run = 0; m_miss = 0;
      m_ecnt = 0; m_locked = 0; m_since = 0; m_period = 0;
      return;
    end
    if (old != 2) m_since = 0;
    if (!vld) return;
    m_zd = (d == 0);
    if (old == 0) begin
      if (d != 0) begin
        m_pred = nx(d); m_run = 0; m_mode = 1;
      end
    end else if (old == 1) begin
      if (d == 0) begin
        m_mode = 0; m_run = 0;
      end else if (d == m_pred) begin
        m_pred = nx(d);
        m_run++;
        if (m_run == LOCK_CNT) begin
          m_mode = 2; m_run = 0;
        end
      end else begin
        m_pred = nx(d); m_run = 0;
      end
    end else begin
      p = m_pred;
      m_pred = nx(p);
      if (d == p) m_miss = 0;
      else begin
        m_err = 1;
        if (m_ecnt < ECMAX) m_ecnt++;
        m_miss++;
        if (m_miss == MISS_MAX) begin
          m_mode = 0; m_miss = 0;
        end
      end
      if (d == 1) begin
        if (m_since > 0) begin
          m_pv = 1; m_period = m_since;
        end
        m_since = 1;
      end else if (m_since > 0) begin
        m_since = (m_since + 1 > 31) ? 31 : m_since + 1;
      end
    end
    m_locked = (m_mode == 2);
  endtask

  task automatic step(bit vld, int d);
    logic [3:0] dv;
    dv = d[3:0];
    bus.din_vld = vld;
    bus.din     = dv;
    @(posedge clk);
    model(reset, vld, d);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1, 1);
    step(1, 1);
    n_checks++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got %h want 0", obs());
    end
    reset = 1'b0;
  endtask

  task automatic test_lock();
    g = 1;
    for (int i = 1; i <= 5; i++) begin
      step(1, g);
      g = nx(g);
      n_checks++;
      if (bus.locked !== (i == 5) || bus.err !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_rise s%0d locked %b err %b", i, bus.locked, bus.err);
      end
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL lock_model got %h want %h", obs(), expv());
      end
    end
  endtask

  task automatic test_single_err();
    while (g != 13) begin
      step(1, g);
      g = nx(g);
    end
    step(1, 12);
    g = nx(g);
    n_checks++;
    if (bus.err !== 1'b1 || bus.err_cnt !== 1 || bus.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL single_err err %b cnt %0d locked %b want 1 1 1",
               bus.err, bus.err_cnt, bus.locked);
    end
    step(1, g);
    g = nx(g);
    n_checks++;
    if (bus.err !== 1'b0 || bus.locked !== 1'b1 || obs() !== expv()) begin
      n_fail++;
      $display("FAIL freewheel got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_drop_lock();
    for (int k = 0; k < 3; k++) begin
      step(1, nx(nx(g)));
      g = nx(g);
      n_checks++;
      if (bus.err !== 1'b1 || bus.locked !== (k != 2)) begin
        n_fail++;
        $display("FAIL drop_lock k%0d err %b locked %b", k, bus.err, bus.locked);
      end
    end
    n_checks++;
    if (bus.err_cnt !== 4) begin
      n_fail++;
      $display("FAIL drop_cnt got %0d want 4", bus.err_cnt);
    end
    for (int i = 1; i <= 5; i++) begin
      step(1, g);
      g = nx(g);
      n_checks++;
      if (bus.locked !== (i == 5) || obs() !== expv()) begin
        n_fail++;
        $display("FAIL relock s%0d got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_zero();
    step(1, 0);
    g = nx(g);
    n_checks++;
    if (bus.zero_det !== 1'b1 || bus.err !== 1'b1 || bus.err_cnt !== 5) begin
      n_fail++;
      $display("FAIL zero_locked zd %b err %b cnt %0d want 1 1 5",
               bus.zero_det, bus.err, bus.err_cnt);
    end
    step(1, 0);
    step(1, 0);
    n_checks++;
    if (bus.locked !== 1'b0 || bus.err_cnt !== 7) begin
      n_fail++;
      $display("FAIL zero_drop locked %b cnt %0d want 0 7", bus.locked, bus.err_cnt);
    end
    step(1, 0);
    n_checks++;
    if (bus.zero_det !== 1'b1 || bus.err !== 1'b0 || obs() !== expv()) begin
      n_fail++;
      $display("FAIL zero_search got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_saturate();
    for (int r = 0; r < 100; r++) begin
      for (int i = 0; i < 8; i++) begin
        if (i < 5) step(1, g);
        else step(1, nx(nx(g)));
        g = nx(g);
        n_checks++;
        if (obs() !== expv()) begin
          n_fail++;
          $display("FAIL saturate r%0d got %h want %h", r, obs(), expv());
        end
      end
    end
    n_checks++;
    if (bus.err_cnt !== ECMAX[ECW-1:0]) begin
      n_fail++;
      $display("FAIL sat_cnt got %0d want %0d", bus.err_cnt, ECMAX);
    end
  endtask

  task automatic test_reset_mid_lock();
    for (int i = 0; i < 6; i++) begin
      step(1, g);
      g = nx(g);
    end
    n_checks++;
    if (bus.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset locked %b want 1", bus.locked);
    end
    reset = 1'b1;
    step(1, 0);
    reset = 1'b0;
    n_checks++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got %h want 0", obs());
    end
    for (int i = 1; i <= 5; i++) begin
      step(1, g);
      g = nx(g);
      n_checks++;
      if (bus.locked !== (i == 5)) begin
        n_fail++;
        $display("FAIL post_reset s%0d locked %b", i, bus.locked);
      end
    end
  endtask

  task automatic test_random();
    int r;
    bit v;
    int d;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 80) d = g;
      else if (r < 90) d = 0;
      else d = $urandom_range(0, 15);
      step(v, d);
      if (v) g = nx(g);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random c%0d got %h want %h", c, obs(), expv());
      end
    end
    reset = 1'b0;
  endtask

`ifdef LFSR4_CHK_PERIOD_EN
  task automatic test_period();
    int pulses;
    pulses = 0;
    reset = 1'b1;
    step(0, 0);
    reset = 1'b0;
    g = 1;
    for (int i = 0; i < 5; i++) begin
      step(1, g);
      g = nx(g);
    end
    for (int c = 0; c < 80; c++) begin
      step(c[0] == 1'b0, g);
      if (c[0] == 1'b0) g = nx(g);
      n_checks++;
      if (bus.period_vld !== m_pv[0] || bus.period !== m_period[4:0]) begin
        n_fail++;
        $display("FAIL period c%0d got %b/%0d want %0d/%0d",
                 c, bus.period_vld, bus.period, m_pv, m_period);
      end
      if (bus.period_vld === 1'b1) begin
        pulses++;
        n_checks++;
        if (bus.period !== 5'd15) begin
          n_fail++;
          $display("FAIL period_val got %0d want 15", bus.period);
        end
      end
    end
    n_checks++;
    if (pulses < 2) begin
      n_fail++;
      $display("FAIL period_pulses got %0d want >=2", pulses);
    end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    bus.din_vld = 1'b0;
    bus.din     = 4'd0;
    model(1, 0, 0);
    test_reset();
    test_lock();
    test_single_err();
    test_drop_lock();
    test_zero();
    test_saturate();
    test_reset_mid_lock();
    test_random();
`ifdef LFSR4_CHK_PERIOD_EN
    test_period();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
